// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_pkg                                                    |
// | Description : Shared constants for the AES scratch-memory subsystem:     |
// |               control-register bit positions, mode encodings, scratch    |
// |               RAM layout (input/result bases, depth) and the             |
// |               end-of-input sentinel word.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package aes_pkg;

  // AES control register layout
  localparam int unsigned AES_CTRL_W    = 3;
  localparam int unsigned AES_CTRL_ENC  = 0;
  localparam int unsigned AES_CTRL_DEC  = 1;
  localparam int unsigned AES_CTRL_INIT = 2;

  // mode_in encodings
  localparam logic ENCRYPT = 1'b1;
  localparam logic DECRYPT = 1'b0;

  // Scratch RAM layout
  localparam int unsigned AES_SCRATCH_DEPTH = 1024;
  localparam int unsigned AES_IN_BASE       = 0;
  localparam int unsigned AES_OUT_BASE      = 257;
  localparam logic [31:0] AES_SENTINEL      = 32'hDEADBEEF;

  // Control word that starts the engine in the requested direction.
  function automatic logic [AES_CTRL_W-1:0] aes_ctrl_word(input logic mode);
    logic [AES_CTRL_W-1:0] w;
    w                = '0;
    w[AES_CTRL_INIT] = 1'b1;
    w[AES_CTRL_ENC]  = (mode == ENCRYPT);
    w[AES_CTRL_DEC]  = (mode == DECRYPT);
    return w;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_loader                                                 |
// | Description : Host-side sequencer for the AES scratch RAM. Streams input |
// |               words into the input region, zero-pads to a multiple of 4, |
// |               appends the sentinel, kicks the engine, waits for          |
// |               completion and streams the result region back out.         |
// | Ports       : clk_in/rst_in      clock, sync active-high reset           |
// |               start_in/mode_in   job start, 1=encrypt 0=decrypt          |
// |               s_*                input word stream (valid/ready)         |
// |               mem_*              scratch RAM port (write + read)         |
// |               aes_ctrl_out       {init, decrypt, encrypt}                |
// |               aes_complete_in    engine writeback finished               |
// |               m_*                result word stream (valid/ready)        |
// |               busy/done/error    job status                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aes_loader
  import aes_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned IN_BASE   = AES_IN_BASE,
  parameter int unsigned OUT_BASE  = AES_OUT_BASE,
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] SENTINEL  = AES_SENTINEL,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  mode_in,
  input  logic [31:0]           s_data_in,
  input  logic                  s_valid_in,
  input  logic                  s_last_in,
  output logic                  s_ready_out,
  output logic [3:0]            mem_we_out,
  output logic [ADDR_W-1:0]     mem_addr_out,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in,
  output logic [AES_CTRL_W-1:0] aes_ctrl_out,
  input  logic                  aes_complete_in,
  output logic [31:0]           m_data_out,
  output logic                  m_valid_out,
  output logic                  m_last_out,
  input  logic                  m_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_PAD      = 4'd2,
    ST_TERM     = 4'd3,
    ST_KICK     = 4'd4,
    ST_WAIT     = 4'd5,
    ST_RD_ISSUE = 4'd6,
    ST_RD_WAIT  = 4'd7,
    ST_RD_HOLD  = 4'd8,
    ST_FINISH   = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  s_ready_q, s_ready_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic [AES_CTRL_W-1:0] aes_ctrl_q, aes_ctrl_d;
  logic [31:0]           m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [CNT_W-1:0]  wcnt_inc;
  logic [CNT_W-1:0]  rcnt_inc;
  logic [ADDR_W-1:0] in_addr;
  logic              s_hs;

  assign wcnt_inc = wcnt_q + CNT_W'(1);
  assign rcnt_inc = rcnt_q + CNT_W'(1);
  // wcnt never exceeds MAX_WORDS, so the truncation to ADDR_W is lossless.
  assign in_addr  = ADDR_W'(IN_BASE) + wcnt_q[ADDR_W-1:0];
  assign s_hs     = s_ready_q & s_valid_in;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    lat_d      = lat_q;
    s_ready_d  = 1'b0;
    mem_we_d   = 4'h0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    aes_ctrl_d = aes_ctrl_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          mode_d    = mode_in;
          wcnt_d    = '0;
          s_ready_d = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        s_ready_d = 1'b1;
        if (s_hs) begin
          mem_we_d   = 4'hF;
          mem_addr_d = in_addr;
          mem_data_d = s_data_in;
          wcnt_d     = wcnt_inc;
          if (s_last_in) begin
            s_ready_d = 1'b0;
            state_d   = (wcnt_inc[1:0] == 2'b00) ? ST_TERM : ST_PAD;
          end else if (wcnt_inc == CNT_W'(MAX_WORDS)) begin
            // No room left for the sentinel: abandon the job without kicking.
            s_ready_d = 1'b0;
            error_d   = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_PAD: begin
        mem_we_d   = 4'hF;
        mem_addr_d = in_addr;
        mem_data_d = 32'h0;
        wcnt_d     = wcnt_inc;
        if (wcnt_inc[1:0] == 2'b00) begin
          state_d = ST_TERM;
        end
      end

      ST_TERM: begin
        mem_we_d   = 4'hF;
        mem_addr_d = in_addr;
        mem_data_d = SENTINEL;
        state_d    = ST_KICK;
      end

      ST_KICK: begin
        aes_ctrl_d = aes_ctrl_word(mode_q);
        rcnt_d     = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (aes_complete_in) begin
          // Launch the first read address now so it is on the bus during RD_ISSUE.
          mem_addr_d = ADDR_W'(OUT_BASE) + rcnt_q[ADDR_W-1:0];
          state_d    = ST_RD_ISSUE;
        end
      end

      ST_RD_ISSUE: begin
        lat_d   = '0;
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // Address was presented in RD_ISSUE; data is valid RD_LAT cycles later.
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          m_data_d  = mem_data_in;
          m_valid_d = 1'b1;
          m_last_d  = (rcnt_q == (wcnt_q - CNT_W'(1)));
          state_d   = ST_RD_HOLD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_RD_HOLD: begin
        if (m_ready_in) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          rcnt_d    = rcnt_inc;
          if (m_last_q) begin
            // Dropping the control word clears the engine's internal counters.
            aes_ctrl_d = '0;
            state_d    = ST_FINISH;
          end else begin
            mem_addr_d = ADDR_W'(OUT_BASE) + rcnt_inc[ADDR_W-1:0];
            state_d    = ST_RD_ISSUE;
          end
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      lat_q      <= '0;
      s_ready_q  <= 1'b0;
      mem_we_q   <= 4'h0;
      mem_addr_q <= '0;
      mem_data_q <= 32'h0;
      aes_ctrl_q <= '0;
      m_data_q   <= 32'h0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      lat_q      <= lat_d;
      s_ready_q  <= s_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      aes_ctrl_q <= aes_ctrl_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign s_ready_out  = s_ready_q;
  assign mem_we_out   = mem_we_q;
  assign mem_addr_out = mem_addr_q;
  assign mem_data_out = mem_data_q;
  assign aes_ctrl_out = aes_ctrl_q;
  assign m_data_out   = m_data_q;
  assign m_valid_out  = m_valid_q;
  assign m_last_out   = m_last_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign error_out    = error_q;

endmodule : aes_loader
`default_nettype wire

// File: tb/tb_aes_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_aes_loader                                              |
// | Description : Directed self-checking bench for aes_loader. Provides a    |
// |               1024x32 scratch RAM with a 2-cycle read pipe and a stub    |
// |               engine (encrypt = word + 01010101, decrypt = word -        |
// |               01010101, applied up to the sentinel).                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_aes_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in, mode_in;
  logic [31:0] s_data_in;
  logic        s_valid_in, s_last_in, s_ready_out;
  logic [3:0]  mem_we_out;
  logic [9:0]  mem_addr_out;
  logic [31:0] mem_data_out, mem_data_in;
  logic [2:0]  aes_ctrl_out;
  logic        aes_complete_in, stray_complete, eng_complete;
  logic [31:0] m_data_out;
  logic        m_valid_out, m_last_out, m_ready_in;
  logic        busy_out, done_out, error_out;

  always #5 clk = ~clk;

  aes_loader dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start_in),
    .mode_in         (mode_in),
    .s_data_in       (s_data_in),
    .s_valid_in      (s_valid_in),
    .s_last_in       (s_last_in),
    .s_ready_out     (s_ready_out),
    .mem_we_out      (mem_we_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_out    (mem_data_out),
    .mem_data_in     (mem_data_in),
    .aes_ctrl_out    (aes_ctrl_out),
    .aes_complete_in (aes_complete_in),
    .m_data_out      (m_data_out),
    .m_valid_out     (m_valid_out),
    .m_last_out      (m_last_out),
    .m_ready_in      (m_ready_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  // ---------------- RAM + stub engine + event counters ----------------
  logic [31:0] ram [0:1023];
  logic [31:0] rd_p1, rd_p2;
  logic [1:0]  eng_state;
  int          eng_cnt;
  int          done_cnt, error_cnt, ctrl_nz_cnt;

  assign mem_data_in     = rd_p2;
  assign aes_complete_in = eng_complete | stray_complete;

  function automatic int sentinel_idx();
    for (int i = 0; i < 257; i++) begin
      if (ram[i] == 32'hDEADBEEF) return i;
    end
    return 257;
  endfunction

  always @(posedge clk) begin
    if (mem_we_out == 4'hF) ram[mem_addr_out] <= mem_data_out;
    rd_p1        <= ram[mem_addr_out];
    rd_p2        <= rd_p1;
    eng_complete <= 1'b0;
    if (!aes_ctrl_out[2]) begin
      eng_state <= 2'd0;
    end else begin
      case (eng_state)
        2'd0: begin
          for (int i = 0; i < 257; i++) begin
            if (i < sentinel_idx()) begin
              if (aes_ctrl_out[1:0] == 2'b01)      ram[257+i] <= ram[i] + 32'h01010101;
              else if (aes_ctrl_out[1:0] == 2'b10) ram[257+i] <= ram[i] - 32'h01010101;
              else                                 ram[257+i] <= 32'hBAD0BAD0;
            end
          end
          eng_cnt   <= 20;
          eng_state <= 2'd1;
        end
        2'd1: begin
          if (eng_cnt == 0) begin
            eng_complete <= 1'b1;
            eng_state    <= 2'd2;
          end else begin
            eng_cnt <= eng_cnt - 1;
          end
        end
        default: ;
      endcase
    end
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hCCCCCCCC;
    end
    if (done_out)             done_cnt    <= done_cnt + 1;
    if (error_out)            error_cnt   <= error_cnt + 1;
    if (aes_ctrl_out != 3'b0) ctrl_nz_cnt <= ctrl_nz_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_s_ready"},  32'(s_ready_out),  32'd0);
    chk({p, "_mem_we"},   32'(mem_we_out),   32'd0);
    chk({p, "_mem_addr"}, 32'(mem_addr_out), 32'd0);
    chk({p, "_mem_data"}, mem_data_out,      32'd0);
    chk({p, "_ctrl"},     32'(aes_ctrl_out), 32'd0);
    chk({p, "_m_valid"},  32'(m_valid_out),  32'd0);
    chk({p, "_m_last"},   32'(m_last_out),   32'd0);
    chk({p, "_m_data"},   m_data_out,        32'd0);
    chk({p, "_busy"},     32'(busy_out),     32'd0);
    chk({p, "_done"},     32'(done_out),     32'd0);
    chk({p, "_error"},    32'(error_out),    32'd0);
  endtask

  task automatic start_job(input logic m);
    start_in = 1'b1;
    mode_in  = m;
    tick();
    start_in = 1'b0;
    mode_in  = ~m;
    chk("start_busy",  32'(busy_out),    32'd1);
    chk("start_ready", 32'(s_ready_out), 32'd1);
  endtask

  // Offer one word; the write must appear the cycle after the handshake.
  task automatic push(input logic [31:0] d, input logic l, input int addr);
    int t;
    t          = 0;
    s_data_in  = d;
    s_valid_in = 1'b1;
    s_last_in  = l;
    while (!s_ready_out && t < 20) begin
      tick();
      t++;
    end
    chk("push_ready", 32'(s_ready_out), 32'd1);
    tick();
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
    chk("wr_we",   32'(mem_we_out),   32'hF);
    chk("wr_addr", 32'(mem_addr_out), 32'(addr));
    chk("wr_data", mem_data_out,      d);
  endtask

  task automatic wait_init(input logic [2:0] exp);
    int t;
    t = 0;
    while (!aes_ctrl_out[2] && t < 20) begin
      tick();
      t++;
    end
    chk("ctrl_kick", 32'(aes_ctrl_out), 32'(exp));
    chk("wait_we",   32'(mem_we_out),   32'd0);
  endtask

  task automatic pop(input logic [31:0] exp, input logic exp_last, input int hold);
    int t;
    t = 0;
    while (!m_valid_out && t < 100) begin
      tick();
      t++;
    end
    chk("m_valid", 32'(m_valid_out), 32'd1);
    chk("m_data",  m_data_out,       exp);
    chk("m_last",  32'(m_last_out),  32'(exp_last));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("bp_data",  m_data_out,       exp);
      chk("bp_valid", 32'(m_valid_out), 32'd1);
    end
    m_ready_in = 1'b1;
    tick();
    m_ready_in = 1'b0;
    chk("m_valid_drop", 32'(m_valid_out), 32'd0);
  endtask

  task automatic finish_job(input int done_before);
    chk("fin_ctrl", 32'(aes_ctrl_out), 32'd0);
    chk("fin_busy", 32'(busy_out),     32'd1);
    tick();
    chk("done_pulse", 32'(done_out), 32'd1);
    chk("done_busy",  32'(busy_out), 32'd0);
    tick();
    chk("done_once", 32'(done_cnt - done_before), 32'd1);
    chk("done_drop", 32'(done_out),               32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int snap_done, snap_err, snap_ctrl;

  initial begin
    rst            = 1'b1;
    start_in       = 1'b0;
    mode_in        = 1'b0;
    s_data_in      = 32'h0;
    s_valid_in     = 1'b0;
    s_last_in      = 1'b0;
    m_ready_in     = 1'b0;
    stray_complete = 1'b0;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // complete while IDLE does nothing
    stray_complete = 1'b1;
    tick();
    stray_complete = 1'b0;
    tick();
    chk("stray_idle_busy", 32'(busy_out), 32'd0);

    // Basic encrypt, with a start pulse mid-load that must be ignored
    snap_done = done_cnt;
    start_job(1'b1);
    push(32'h3243F6A8, 1'b0, 0);
    push(32'h885A308D, 1'b0, 1);
    start_in = 1'b1;
    mode_in  = 1'b0;
    push(32'h313198A2, 1'b0, 2);
    start_in = 1'b0;
    push(32'hE0370734, 1'b1, 3);
    wait_init(3'b101);
    chk("basic_sentinel", ram[4], 32'hDEADBEEF);
    pop(32'h3344F7A9, 1'b0, 0);
    pop(32'h895B318E, 1'b0, 0);
    pop(32'h323299A3, 1'b0, 0);
    pop(32'hE1380835, 1'b1, 0);
    finish_job(snap_done);

    // Padding: 5 words, backpressure on word 2, stray complete during LOAD
    snap_done = done_cnt;
    start_job(1'b1);
    push(32'h00000001, 1'b0, 0);
    push(32'h00000002, 1'b0, 1);
    stray_complete = 1'b1;
    tick();
    stray_complete = 1'b0;
    chk("stray_load_ready", 32'(s_ready_out), 32'd1);
    push(32'h00000003, 1'b0, 2);
    push(32'h00000004, 1'b0, 3);
    push(32'h00000005, 1'b1, 4);
    wait_init(3'b101);
    chk("pad_5", ram[5], 32'h0);
    chk("pad_6", ram[6], 32'h0);
    chk("pad_7", ram[7], 32'h0);
    chk("pad_sentinel", ram[8], 32'hDEADBEEF);
    pop(32'h01010102, 1'b0, 0);
    pop(32'h01010103, 1'b0, 10);
    pop(32'h01010104, 1'b0, 0);
    pop(32'h01010105, 1'b0, 0);
    pop(32'h01010106, 1'b0, 0);
    pop(32'h01010101, 1'b0, 0);
    pop(32'h01010101, 1'b0, 0);
    pop(32'h01010101, 1'b1, 0);
    finish_job(snap_done);

    // Round trip: decrypt the basic ciphertext back to the plaintext
    snap_done = done_cnt;
    start_job(1'b0);
    push(32'h3344F7A9, 1'b0, 0);
    push(32'h895B318E, 1'b0, 1);
    push(32'h323299A3, 1'b0, 2);
    push(32'hE1380835, 1'b1, 3);
    wait_init(3'b110);
    pop(32'h3243F6A8, 1'b0, 0);
    pop(32'h885A308D, 1'b0, 0);
    pop(32'h313198A2, 1'b0, 0);
    pop(32'hE0370734, 1'b1, 0);
    finish_job(snap_done);

    // Reset while waiting on the engine, then a single-word job
    start_job(1'b1);
    push(32'h11111111, 1'b0, 0);
    push(32'h22222222, 1'b1, 1);
    wait_init(3'b101);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    tick();
    snap_done = done_cnt;
    start_job(1'b1);
    push(32'hA0000000, 1'b1, 0);
    wait_init(3'b101);
    chk("single_pad", ram[3], 32'h0);
    chk("single_sentinel", ram[4], 32'hDEADBEEF);
    pop(32'hA1010101, 1'b0, 0);
    pop(32'h01010101, 1'b0, 0);
    pop(32'h01010101, 1'b0, 0);
    pop(32'h01010101, 1'b1, 0);
    finish_job(snap_done);

    // Overflow: 256 words without last
    snap_err  = error_cnt;
    snap_ctrl = ctrl_nz_cnt;
    start_job(1'b1);
    for (int i = 0; i < 256; i++) push(32'h10000000 + 32'(i), 1'b0, i);
    chk("ovf_error", 32'(error_out),   32'd1);
    chk("ovf_busy",  32'(busy_out),    32'd0);
    chk("ovf_ready", 32'(s_ready_out), 32'd0);
    s_data_in  = 32'h100000FF + 32'd1;
    s_valid_in = 1'b1;
    tick();
    chk("ovf_error_drop", 32'(error_out), 32'd0);
    tick();
    chk("ovf_no_accept", 32'(s_ready_out), 32'd0);
    s_valid_in = 1'b0;
    tick();
    chk("ovf_error_once", 32'(error_cnt - snap_err), 32'd1);
    chk("ovf_ctrl_zero",  32'(ctrl_nz_cnt - snap_ctrl), 32'd0);
    chk("ovf_no_sentinel", ram[256], 32'hCCCCCCCC);

    // Exactly 256 words with last: sentinel lands at address 256, no error
    snap_done = done_cnt;
    snap_err  = error_cnt;
    start_job(1'b1);
    for (int i = 0; i < 256; i++) push(32'(i), (i == 255), i);
    wait_init(3'b101);
    chk("full_sentinel", ram[256], 32'hDEADBEEF);
    for (int i = 0; i < 256; i++) pop(32'(i) + 32'h01010101, (i == 255), 0);
    finish_job(snap_done);
    chk("full_no_error", 32'(error_cnt - snap_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_aes_loader
`default_nettype wire
